// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared constants and types for the switch debouncer
package sw_pkg;

  // 10 ms at 50 MHz
  localparam int STABLE_CYCLES_DEF = 500000;
  // Short window so simulations stay fast
  localparam int STABLE_CYCLES_SIM = 8;
  // Wide enough for the full legal window range
  localparam int CNT_W_DEF = 24;

  // Filter state is implied by the counter: zero means stable, anything else is settling
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } filt_state_e;

  // Smallest counter width w with 2^w > cycles
  function automatic int cnt_width(input int cycles);
    int w;
    w = 1;
    while ((1 << w) <= cycles) w++;
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - switch pins in, debounced levels and strobes out
interface sw_debounce_if #(
  parameter int N = 4
);
  logic [N-1:0] sw_in;
  logic [N-1:0] sw_db;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic [N-1:0] sw_busy;

  // Switch side: drives pins, observes conditioned outputs
  modport master (
    output sw_in,
    input  sw_db, sw_rise, sw_fall, sw_busy
  );

  // Debouncer side
  modport slave (
    input  sw_in,
    output sw_db, sw_rise, sw_fall, sw_busy
  );
endinterface

// File: rtl/sw_debounce_ch.sv
// rtl/sw_debounce_ch.sv - one channel: 2-flop synchroniser, stability counter, edge strobes
module sw_debounce_ch
  import sw_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Counter value on the edge that completes the window
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             db_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  filt_state_e      state;

  // State register: synchroniser, counter, accepted level and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      cnt  <= cnt_nxt;
      db   <= db_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

  // Decode the filter state from the counter
  always_comb begin
    state = (cnt == '0) ? ST_STABLE : ST_SETTLING;
  end

  // Next state: start, extend, abandon or complete a settling window
  always_comb begin
    cnt_nxt  = cnt;
    db_nxt   = db;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    unique case (state)
      ST_STABLE: begin
        if (s2 != db) begin
          if (STABLE_CYCLES == 1) begin
            // A one-cycle window accepts the new level on first sight
            db_nxt   = s2;
            rise_nxt = s2;
            fall_nxt = ~s2;
          end else begin
            cnt_nxt = CNT_W'(1);
          end
        end
      end
      ST_SETTLING: begin
        if (s2 == db) begin
          // Bounced back to the accepted level: drop the pending change quietly
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          db_nxt   = s2;
          rise_nxt = s2;
          fall_nxt = ~s2;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  // Output decode: busy while a window is open, taken straight from the counter register
  always_comb begin
    busy = (state == ST_SETTLING);
  end

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - N independent debounce channels wired to the switch interface
module sw_debounce
  import sw_pkg::*;
#(
  parameter int N             = 4,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  sw_debounce_if.slave bus
);

  logic [N-1:0] db_v;
  logic [N-1:0] rise_v;
  logic [N-1:0] fall_v;
  logic [N-1:0] busy_v;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sw_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (bus.sw_in[i]),
      .db   (db_v[i]),
      .rise (rise_v[i]),
      .fall (fall_v[i]),
      .busy (busy_v[i])
    );
  end

  assign bus.sw_db   = db_v;
  assign bus.sw_rise = rise_v;
  assign bus.sw_fall = fall_v;
  assign bus.sw_busy = busy_v;

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - scoreboard bench with a run-length reference model
module tb_sw_debounce;
  import sw_pkg::*;

  localparam int N  = 4;
  localparam int SC = STABLE_CYCLES_SIM;
  localparam int CW = cnt_width(SC);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sw_debounce_if #(.N(N)) bus ();

  sw_debounce #(
    .N            (N),
    .STABLE_CYCLES(SC),
    .CNT_W        (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [N-1:0] db;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: a level is accepted once the synchronised pin has disagreed
  // with the accepted level for SC consecutive edges.
  logic [N-1:0] m_s1 = '0;
  logic [N-1:0] m_s2 = '0;
  logic [N-1:0] m_db = '0;
  int           m_run[N];

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model step on every active edge; expected post-edge outputs go to the scoreboard
  always @(posedge clk) begin : model
    exp_t e;
    e = '0;
    if (!rst_n) begin
      m_s1 = '0;
      m_s2 = '0;
      m_db = '0;
      for (int c = 0; c < N; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (m_s2[c] != m_db[c]) m_run[c] = m_run[c] + 1;
        else m_run[c] = 0;
        if (m_run[c] == SC) begin
          m_db[c] = m_s2[c];
          if (m_s2[c]) e.rise[c] = 1'b1;
          else e.fall[c] = 1'b1;
          m_run[c] = 0;
        end
        e.busy[c] = (m_run[c] != 0);
      end
      e.db = m_db;
      m_s2 = m_s1;
      m_s1 = bus.sw_in;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs half a cycle after each edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      if (!rst_n) e = '0;
      check("sw_db",   bus.sw_db,   e.db);
      check("sw_rise", bus.sw_rise, e.rise);
      check("sw_fall", bus.sw_fall, e.fall);
      check("sw_busy", bus.sw_busy, e.busy);
      check("rise_and_fall", bus.sw_rise & bus.sw_fall, '0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic async_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check("async_rst_db",   bus.sw_db,   '0);
    check("async_rst_rise", bus.sw_rise, '0);
    check("async_rst_busy", bus.sw_busy, '0);
    tick(hold);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [N-1:0] v;
    // 1: pins already high during reset, accepted as a rise after release
    bus.sw_in = 4'hF;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(14);
    bus.sw_in = 4'h0;
    tick(12);
    // 2: clean press on ch0
    bus.sw_in[0] = 1'b1;
    tick(12);
    // 3: bounce on ch1, then settle high
    for (int k = 0; k < 4; k++) begin
      bus.sw_in[1] = ~k[0];
      tick(3);
    end
    bus.sw_in[1] = 1'b1;
    tick(12);
    // 4: glitch on ch2 one cycle short of the window
    bus.sw_in[2] = 1'b1;
    tick(SC - 1);
    bus.sw_in[2] = 1'b0;
    tick(12);
    // 5: press then release on ch3
    bus.sw_in[3] = 1'b1;
    tick(12);
    bus.sw_in[3] = 1'b0;
    tick(12);
    // 6: ch0 change interrupted by reset with its counter at 5
    bus.sw_in[0] = 1'b0;
    tick(7);
    async_reset(2);
    tick(14);
    // Random toggling with random hold lengths around the window size
    for (int r = 0; r < 250; r++) begin
      v = bus.sw_in;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 2) == 0) v[c] = ~v[c];
      bus.sw_in = v;
      if ($urandom_range(0, 60) == 0) async_reset($urandom_range(1, 3));
      tick($urandom_range(1, 12));
    end
    tick(14);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
